// File: rtl/pipe_load_writeback.sv
// Load unit between execute and the register file: issues one or two word reads,
// aligns and extends the result, and writes it back or raises a fault pulse.
module pipe_load_writeback #(
  parameter int SPLIT_MISALIGNED = 1,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_address,
  output logic        mem_valid,
  output logic [31:0] mem_address,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        wb_enable,
  output logic [4:0]  wb_address,
  output logic [31:0] wb_data,
  output logic        fault_misaligned,
  output logic        fault_illegal,
  output logic        fault_timeout,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_LO   = 2'd1,
    READ_HI   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

  state_t        r_state;
  logic [2:0]    r_funct3;
  logic [4:0]    r_rd;
  logic [31:0]   r_addr;
  logic [31:0]   r_lo;
  logic [31:0]   r_hi;
  logic [CW-1:0] r_cnt;
  logic          r_fault_mis;
  logic          r_fault_ill;
  logic          r_fault_to;

  logic          w_illegal;
  logic          w_mis_req;
  logic          w_span;
  logic          w_expire;
  logic [31:0]   w_lo_addr;
  logic [63:0]   w_shifted;
  logic [31:0]   w_result;

  function automatic logic misaligned(input logic [2:0] f3,
                                      input logic [1:0] a);
    logic m;
    m = 1'b0;
    if (f3[1:0] == 2'b01) m = (a == 2'b11);
    if (f3[1:0] == 2'b10) m = (a != 2'b00);
    return m;
  endfunction

  assign w_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
  assign w_mis_req = misaligned(req_funct3, req_address[1:0]);
  assign w_span    = misaligned(r_funct3, r_addr[1:0]);
  assign w_expire  = (TIMEOUT_CYCLES != 0) && (r_cnt == TMAX);
  assign w_lo_addr = {r_addr[31:2], 2'b00};

  // Byte lane select across the concatenated word pair, then extend.
  assign w_shifted = {r_hi, r_lo} >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_result = w_shifted[31:0];
    unique case (1'b1)
      (r_funct3 == 3'b000): w_result = {{24{w_shifted[7]}}, w_shifted[7:0]};
      (r_funct3 == 3'b001): w_result = {{16{w_shifted[15]}}, w_shifted[15:0]};
      (r_funct3 == 3'b100): w_result = {24'd0, w_shifted[7:0]};
      (r_funct3 == 3'b101): w_result = {16'd0, w_shifted[15:0]};
      default:              w_result = w_shifted[31:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_funct3    <= 3'd0;
      r_rd        <= 5'd0;
      r_addr      <= 32'd0;
      r_lo        <= 32'd0;
      r_hi        <= 32'd0;
      r_cnt       <= '0;
      r_fault_mis <= 1'b0;
      r_fault_ill <= 1'b0;
      r_fault_to  <= 1'b0;
    end else begin
      r_fault_mis <= 1'b0;
      r_fault_ill <= 1'b0;
      r_fault_to  <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (req_valid) begin
              r_funct3 <= req_funct3;
              r_rd     <= req_rd;
              r_addr   <= req_address;
              r_lo     <= 32'd0;
              r_hi     <= 32'd0;
              r_cnt    <= '0;
              if (w_illegal) begin
                r_fault_ill <= 1'b1;
              end else if (w_mis_req && SPLIT_MISALIGNED == 0) begin
                r_fault_mis <= 1'b1;
              end else begin
                r_state <= READ_LO;
              end
            end
          end
          READ_LO: begin
            if (mem_ready) begin
              r_lo    <= mem_rdata;
              r_cnt   <= '0;
              r_state <= w_span ? READ_HI : WRITEBACK;
            end else if (w_expire) begin
              r_fault_to <= 1'b1;
              r_cnt      <= '0;
              r_state    <= IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          READ_HI: begin
            if (mem_ready) begin
              r_hi    <= mem_rdata;
              r_cnt   <= '0;
              r_state <= WRITEBACK;
            end else if (w_expire) begin
              r_fault_to <= 1'b1;
              r_cnt      <= '0;
              r_state    <= IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          WRITEBACK: r_state <= IDLE;
        endcase
      end
    end
  end

  // The reset term keeps req_ready low while rst is held.
  assign req_ready = rst && (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign mem_valid = (r_state == READ_LO) || (r_state == READ_HI);

  always_comb begin
    mem_address = 32'd0;
    if (r_state == READ_LO) mem_address = w_lo_addr;
    if (r_state == READ_HI) mem_address = w_lo_addr + 32'd4;
  end

  assign wb_enable  = (r_state == WRITEBACK) && (r_rd != 5'd0);
  assign wb_address = (r_state == WRITEBACK) ? r_rd : 5'd0;
  assign wb_data    = (r_state == WRITEBACK) ? w_result : 32'd0;

  assign fault_misaligned = r_fault_mis;
  assign fault_illegal    = r_fault_ill;
  assign fault_timeout    = r_fault_to;

endmodule

// File: tb/tb_pipe_load_writeback.sv
// Directed bench for pipe_load_writeback: split-enabled unit with a short
// timeout, plus a second unit with splitting disabled.
module tb_pipe_load_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        b_req_valid = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [4:0]  req_rd = 5'd0;
  logic [31:0] req_address = 32'd0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  logic        req_ready, mem_valid, wb_enable, busy;
  logic [31:0] mem_address, wb_data;
  logic [4:0]  wb_address;
  logic        f_mis, f_ill, f_to;

  logic        b_req_ready, b_mem_valid, b_wb_enable, b_busy;
  logic [31:0] b_mem_address, b_wb_data;
  logic [4:0]  b_wb_address;
  logic        b_f_mis, b_f_ill, b_f_to;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  pipe_load_writeback #(.SPLIT_MISALIGNED(1), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_rd(req_rd), .req_address(req_address),
    .mem_valid(mem_valid), .mem_address(mem_address),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_enable(wb_enable), .wb_address(wb_address), .wb_data(wb_data),
    .fault_misaligned(f_mis), .fault_illegal(f_ill),
    .fault_timeout(f_to), .busy(busy)
  );

  pipe_load_writeback #(.SPLIT_MISALIGNED(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_funct3(req_funct3), .req_rd(req_rd), .req_address(req_address),
    .mem_valid(b_mem_valid), .mem_address(b_mem_address),
    .mem_ready(1'b0), .mem_rdata(32'd0),
    .wb_enable(b_wb_enable), .wb_address(b_wb_address), .wb_data(b_wb_data),
    .fault_misaligned(b_f_mis), .fault_illegal(b_f_ill),
    .fault_timeout(b_f_to), .busy(b_busy)
  );

  task automatic issue(input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] a);
    @(negedge clk);
    req_valid = 1'b1;
    req_funct3 = f3;
    req_rd = rd;
    req_address = a;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Runs a load with mem_ready on the first cycle of every read.
  task automatic do_load(input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] lo,
                         input logic [31:0] hi,
                         output logic [31:0] a_lo, output logic [31:0] a_hi,
                         output logic en, output logic [4:0] wa,
                         output logic [31:0] wd);
    issue(f3, rd, a);
    a_lo = mem_address;
    a_hi = 32'hxxxxxxxx;
    mem_ready = 1'b1;
    mem_rdata = lo;
    @(negedge clk);
    if (mem_valid) begin
      a_hi = mem_address;
      mem_rdata = hi;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    en = wb_enable;
    wa = wb_address;
    wd = wb_data;
  endtask

  task automatic test_reset();
    nchecks++;
    if (req_ready !== 1'b0 || mem_valid !== 1'b0 || busy !== 1'b0 ||
        wb_enable !== 1'b0 || wb_data !== 32'd0) begin
      nerrors++;
      $display("FAIL reset_hold: rdy=%b mv=%b busy=%b wb=%b wd=%h, need 0s",
               req_ready, mem_valid, busy, wb_enable, wb_data);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    nchecks++;
    if (req_ready !== 1'b1 || f_mis || f_ill || f_to || wb_enable) begin
      nerrors++;
      $display("FAIL reset_release: rdy=%b faults=%b%b%b wb=%b, need 1 0",
               req_ready, f_mis, f_ill, f_to, wb_enable);
    end
  endtask

  task automatic test_lw();
    logic [31:0] alo, ahi, wd;
    logic en;
    logic [4:0] wa;
    do_load(3'b010, 5'd5, 32'h100, 32'hDEADBEEF, 32'h0, alo, ahi, en, wa, wd);
    nchecks++;
    if (alo !== 32'h100) begin
      nerrors++;
      $display("FAIL lw_addr: got %h need 00000100", alo);
    end
    nchecks++;
    if (en !== 1'b1 || wa !== 5'd5 || wd !== 32'hDEADBEEF) begin
      nerrors++;
      $display("FAIL lw_wb: en=%b rd=%0d data=%h need 1 5 deadbeef",
               en, wa, wd);
    end
    @(negedge clk);
    nchecks++;
    if (wb_enable !== 1'b0 || req_ready !== 1'b1 || wb_data !== 32'd0) begin
      nerrors++;
      $display("FAIL lw_after: wb=%b rdy=%b wd=%h need 0 1 0",
               wb_enable, req_ready, wb_data);
    end
  endtask

  task automatic test_extend();
    logic [31:0] alo, ahi, wd;
    logic en;
    logic [4:0] wa;
    do_load(3'b000, 5'd7, 32'h103, 32'h80FFFFFF, 32'h0, alo, ahi, en, wa, wd);
    nchecks++;
    if (wd !== 32'hFFFFFF80 || alo !== 32'h100) begin
      nerrors++;
      $display("FAIL lb: data=%h addr=%h need ffffff80 00000100", wd, alo);
    end
    do_load(3'b100, 5'd7, 32'h103, 32'h80FFFFFF, 32'h0, alo, ahi, en, wa, wd);
    nchecks++;
    if (wd !== 32'h00000080) begin
      nerrors++;
      $display("FAIL lbu: data=%h need 00000080", wd);
    end
    do_load(3'b001, 5'd9, 32'h102, 32'hABCD1234, 32'h0, alo, ahi, en, wa, wd);
    nchecks++;
    if (wd !== 32'hFFFFABCD || wa !== 5'd9) begin
      nerrors++;
      $display("FAIL lh: data=%h rd=%0d need ffffabcd 9", wd, wa);
    end
    do_load(3'b101, 5'd9, 32'h102, 32'hABCD1234, 32'h0, alo, ahi, en, wa, wd);
    nchecks++;
    if (wd !== 32'h0000ABCD) begin
      nerrors++;
      $display("FAIL lhu: data=%h need 0000abcd", wd);
    end
  endtask

  task automatic test_split();
    logic [31:0] alo, ahi, wd;
    logic en;
    logic [4:0] wa;
    do_load(3'b010, 5'd3, 32'h102, 32'h44332211, 32'h88776655,
            alo, ahi, en, wa, wd);
    nchecks++;
    if (alo !== 32'h100 || ahi !== 32'h104) begin
      nerrors++;
      $display("FAIL split_addr: lo=%h hi=%h need 00000100 00000104",
               alo, ahi);
    end
    nchecks++;
    if (en !== 1'b1 || wd !== 32'h66554433) begin
      nerrors++;
      $display("FAIL split_data: en=%b data=%h need 1 66554433", en, wd);
    end
    do_load(3'b001, 5'd4, 32'hFFFFFFFF, 32'h11223344, 32'h55667788,
            alo, ahi, en, wa, wd);
    nchecks++;
    if (alo !== 32'hFFFFFFFC || ahi !== 32'h00000000) begin
      nerrors++;
      $display("FAIL wrap_addr: lo=%h hi=%h need fffffffc 00000000",
               alo, ahi);
    end
    nchecks++;
    if (wd !== 32'hFFFF8811) begin
      nerrors++;
      $display("FAIL wrap_data: data=%h need ffff8811", wd);
    end
  endtask

  task automatic test_rd0();
    logic [31:0] alo, ahi, wd;
    logic en;
    logic [4:0] wa;
    do_load(3'b010, 5'd0, 32'h200, 32'h12345678, 32'h0, alo, ahi, en, wa, wd);
    nchecks++;
    if (alo !== 32'h200 || en !== 1'b0) begin
      nerrors++;
      $display("FAIL rd0: addr=%h en=%b need 00000200 0", alo, en);
    end
  endtask

  task automatic test_illegal();
    issue(3'b011, 5'd2, 32'h100);
    nchecks++;
    if (f_ill !== 1'b1 || mem_valid !== 1'b0 || req_ready !== 1'b1 ||
        wb_enable !== 1'b0) begin
      nerrors++;
      $display("FAIL illegal: fi=%b mv=%b rdy=%b wb=%b need 1 0 1 0",
               f_ill, mem_valid, req_ready, wb_enable);
    end
    @(negedge clk);
    nchecks++;
    if (f_ill !== 1'b0) begin
      nerrors++;
      $display("FAIL illegal_pulse: fi=%b need 0", f_ill);
    end
  endtask

  task automatic test_nosplit();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    b_req_valid = 1'b1;
    req_funct3 = 3'b010;
    req_rd = 5'd3;
    req_address = 32'h102;
    @(negedge clk);
    b_req_valid = 1'b0;
    nchecks++;
    if (b_f_mis !== 1'b1 || b_mem_valid !== 1'b0 || b_req_ready !== 1'b1) begin
      nerrors++;
      $display("FAIL nosplit_fault: fm=%b mv=%b rdy=%b need 1 0 1",
               b_f_mis, b_mem_valid, b_req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (b_mem_valid || b_wb_enable || b_f_mis) seen = 1'b1;
    end
    nchecks++;
    if (seen !== 1'b0) begin
      nerrors++;
      $display("FAIL nosplit_quiet: activity=%b need 0", seen);
    end
  endtask

  task automatic test_timeout();
    logic bad;
    bad = 1'b0;
    issue(3'b010, 5'd6, 32'h300);
    for (int i = 0; i < 4; i++) begin
      if (mem_valid !== 1'b1 || f_to !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    nchecks++;
    if (bad !== 1'b0) begin
      nerrors++;
      $display("FAIL timeout_wait: early exit or pulse, need 4 read cycles");
    end
    nchecks++;
    if (f_to !== 1'b1 || wb_enable !== 1'b0 || req_ready !== 1'b1 ||
        mem_valid !== 1'b0) begin
      nerrors++;
      $display("FAIL timeout: ft=%b wb=%b rdy=%b mv=%b need 1 0 1 0",
               f_to, wb_enable, req_ready, mem_valid);
    end
    @(negedge clk);
    nchecks++;
    if (f_to !== 1'b0 || req_ready !== 1'b1 || wb_enable !== 1'b0) begin
      nerrors++;
      $display("FAIL timeout_after: ft=%b rdy=%b wb=%b need 0 1 0",
               f_to, req_ready, wb_enable);
    end
  endtask

  task automatic test_timeout_race();
    issue(3'b010, 5'd8, 32'h400);
    repeat (3) @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_ready = 1'b0;
    nchecks++;
    if (wb_enable !== 1'b1 || wb_data !== 32'hCAFEF00D || f_to !== 1'b0) begin
      nerrors++;
      $display("FAIL ready_wins: wb=%b data=%h ft=%b need 1 cafef00d 0",
               wb_enable, wb_data, f_to);
    end
  endtask

  task automatic test_flush();
    issue(3'b010, 5'd10, 32'h102);
    mem_ready = 1'b1;
    mem_rdata = 32'h11111111;
    @(negedge clk);
    flush = 1'b1;
    mem_rdata = 32'h22222222;
    @(negedge clk);
    flush = 1'b0;
    mem_ready = 1'b0;
    nchecks++;
    if (mem_valid !== 1'b0 || wb_enable !== 1'b0 || busy !== 1'b0 ||
        f_to || f_mis || f_ill) begin
      nerrors++;
      $display("FAIL flush_hi: mv=%b wb=%b busy=%b need 0 0 0",
               mem_valid, wb_enable, busy);
    end
    @(negedge clk);
    nchecks++;
    if (wb_enable !== 1'b0 || busy !== 1'b0) begin
      nerrors++;
      $display("FAIL flush_after: wb=%b busy=%b need 0 0", wb_enable, busy);
    end
    @(negedge clk);
    req_valid = 1'b1;
    flush = 1'b1;
    req_funct3 = 3'b010;
    req_address = 32'h500;
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b0;
    nchecks++;
    if (busy !== 1'b0 || mem_valid !== 1'b0) begin
      nerrors++;
      $display("FAIL flush_prio: busy=%b mv=%b need 0 0", busy, mem_valid);
    end
  endtask

  task automatic test_reset_mid();
    issue(3'b010, 5'd11, 32'h102);
    mem_ready = 1'b1;
    mem_rdata = 32'h33333333;
    @(negedge clk);
    mem_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    nchecks++;
    if (mem_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0 ||
        mem_address !== 32'd0) begin
      nerrors++;
      $display("FAIL reset_mid: mv=%b busy=%b rdy=%b addr=%h need 0 0 0 0",
               mem_valid, busy, req_ready, mem_address);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    nchecks++;
    if (req_ready !== 1'b1 || wb_enable || f_to || f_mis || f_ill) begin
      nerrors++;
      $display("FAIL reset_mid_release: rdy=%b wb=%b need 1 0",
               req_ready, wb_enable);
    end
  endtask

  task automatic test_idle_ready();
    logic bad;
    bad = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy || wb_enable || mem_valid) bad = 1'b1;
    end
    mem_ready = 1'b0;
    nchecks++;
    if (bad !== 1'b0) begin
      nerrors++;
      $display("FAIL idle_mem_ready: activity=%b need 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_extend();
    test_split();
    test_rd0();
    test_illegal();
    test_nosplit();
    test_timeout();
    test_timeout_race();
    test_flush();
    test_reset_mid();
    test_idle_ready();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
